// File: rtl/valu_lane_sequencer.sv
// ----------------------------------------------------------------------------
// valu_lane_sequencer
//
// Execution-side responder for the SIMD/SIMF ALU controller handshake.
// A start pulse latches the opcode and EXEC mask. The sequencer then walks the
// LANES-wide vector datapath through four passes that cover the whole
// wavefront. Each pass result is masked by its EXEC slice and packed into the
// VCC value. A single-cycle done pulse releases the controller's write-back
// stage.
//
// Ports
//   clk              rising-edge clock
//   rst              synchronous, active-high reset
//   in_alu_start     single-cycle start pulse (ignored while busy)
//   in_alu_control   opcode, sampled with in_alu_start
//   in_exec_value    EXEC mask, sampled with in_alu_start
//   in_pass_cmp      per-lane compare result, sampled when out_pass_capture=1
//   out_busy         operation in flight (state != IDLE)
//   out_alu_opcode   latched opcode
//   out_pass_valid   one-cycle pass issue pulse
//   out_pass_idx     current pass number 0..3
//   out_lane_mask    EXEC slice for the current pass
//   out_pass_capture datapath result for the current pass is valid
//   out_valu_done    one-cycle completion pulse
//   out_vcc_value    assembled compare result, held until next start
// ----------------------------------------------------------------------------
module valu_lane_sequencer #(
    parameter int          LANES        = 16,
    parameter logic [7:0]  LONG_OP_TYPE = 8'h08,
    parameter int          LONG_LAT     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_alu_start,
    input  logic [31:0]          in_alu_control,
    input  logic [4*LANES-1:0]   in_exec_value,
    input  logic [LANES-1:0]     in_pass_cmp,
    output logic                 out_busy,
    output logic [31:0]          out_alu_opcode,
    output logic                 out_pass_valid,
    output logic [1:0]           out_pass_idx,
    output logic [LANES-1:0]     out_lane_mask,
    output logic                 out_pass_capture,
    output logic                 out_valu_done,
    output logic [4*LANES-1:0]   out_vcc_value
);

    localparam int CNT_W = (LONG_LAT > 2) ? $clog2(LONG_LAT) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [31:0]          r_opcode;
    logic [4*LANES-1:0]   r_exec;
    logic [4*LANES-1:0]   r_vcc;
    logic [1:0]           r_idx;
    logic [LANES-1:0]     r_mask;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_long;

    logic                 w_pass_valid;
    logic                 w_capture;
    logic                 w_done;
    logic                 w_last;
    logic                 w_accept;
    logic [1:0]           w_idx_nxt;

    assign w_last    = (r_idx == 2'd3);
    assign w_accept  = (r_state == S_IDLE) && in_alu_start;
    assign w_idx_nxt = r_idx + 2'd1;

    // Next-state and pulse outputs
    always_comb begin
        w_next       = r_state;
        w_pass_valid = 1'b0;
        w_capture    = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (in_alu_start) begin
                    // An all-zero EXEC has nothing to compute: skip straight to done.
                    w_next = (in_exec_value == '0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_pass_valid = 1'b1;
                if (r_long) begin
                    w_next = S_WAIT;
                end else begin
                    // Short ops return their result in the issue cycle itself.
                    w_capture = 1'b1;
                    w_next    = w_last ? S_DONE : S_ISSUE;
                end
            end
            S_WAIT: begin
                if (r_cnt == CNT_W'(1)) begin
                    w_capture = 1'b1;
                    w_next    = w_last ? S_DONE : S_ISSUE;
                end
            end
            S_DONE: begin
                w_done = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_opcode <= '0;
            r_exec   <= '0;
            r_vcc    <= '0;
            r_idx    <= '0;
            r_mask   <= '0;
            r_cnt    <= '0;
            r_long   <= 1'b0;
        end else begin
            r_state <= w_next;

            if (w_accept) begin
                r_opcode <= in_alu_control;
                r_exec   <= in_exec_value;
                r_vcc    <= '0;
                r_idx    <= '0;
                r_mask   <= in_exec_value[LANES-1:0];
                r_long   <= (in_alu_control[31:24] == LONG_OP_TYPE);
            end

            // Counter loads in the issue cycle; capture fires when it reads 1,
            // giving LONG_LAT cycles per pass including the issue cycle.
            if (r_state == S_ISSUE && r_long) begin
                r_cnt <= CNT_W'(LONG_LAT - 1);
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end

            if (w_capture) begin
                r_vcc[LANES*r_idx +: LANES] <= in_pass_cmp & r_mask;
                if (!w_last) begin
                    r_idx  <= w_idx_nxt;
                    r_mask <= r_exec[LANES*w_idx_nxt +: LANES];
                end
            end
        end
    end

    assign out_busy         = (r_state != S_IDLE);
    assign out_alu_opcode   = r_opcode;
    assign out_pass_valid   = w_pass_valid;
    assign out_pass_idx     = r_idx;
    assign out_lane_mask    = r_mask;
    assign out_pass_capture = w_capture;
    assign out_valu_done    = w_done;
    assign out_vcc_value    = r_vcc;

endmodule

// File: tb/tb_valu_lane_sequencer.sv
// ----------------------------------------------------------------------------
// tb_valu_lane_sequencer
//
// Scoreboard bench: each accepted start pushes its expected pass issues,
// captures and completion (cycle, index, mask, VCC) into queues; a monitor on
// the falling edge pops and compares whenever the DUT presents an event, and
// flags events that never appear.
// ----------------------------------------------------------------------------
module tb_valu_lane_sequencer;

    localparam int LANES = 16;
    localparam int LL    = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_alu_start;
    logic [31:0] in_alu_control;
    logic [63:0] in_exec_value;
    logic [15:0] in_pass_cmp;
    logic        out_busy;
    logic [31:0] out_alu_opcode;
    logic        out_pass_valid;
    logic [1:0]  out_pass_idx;
    logic [15:0] out_lane_mask;
    logic        out_pass_capture;
    logic        out_valu_done;
    logic [63:0] out_vcc_value;

    valu_lane_sequencer #(
        .LANES        (LANES),
        .LONG_OP_TYPE (8'h08),
        .LONG_LAT     (LL)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .in_alu_start     (in_alu_start),
        .in_alu_control   (in_alu_control),
        .in_exec_value    (in_exec_value),
        .in_pass_cmp      (in_pass_cmp),
        .out_busy         (out_busy),
        .out_alu_opcode   (out_alu_opcode),
        .out_pass_valid   (out_pass_valid),
        .out_pass_idx     (out_pass_idx),
        .out_lane_mask    (out_lane_mask),
        .out_pass_capture (out_pass_capture),
        .out_valu_done    (out_valu_done),
        .out_vcc_value    (out_vcc_value)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int          cyc;
        logic [1:0]  idx;
        logic [15:0] mask;
        logic [31:0] op;
    } pass_ev_t;

    typedef struct {
        int          cyc;
        logic [63:0] vcc;
        logic [31:0] op;
    } done_ev_t;

    pass_ev_t    issue_q[$];
    pass_ev_t    cap_q[$];
    done_ev_t    done_q[$];
    logic [15:0] cmp_sched [int];
    int          busy_end = -1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: falling edge, DUT outputs are stable here.
    always @(negedge clk) begin : monitor
        pass_ev_t e;
        done_ev_t d;
        if (out_pass_valid === 1'b1) begin
            if (issue_q.size() == 0) begin
                check("issue_unexpected", 64'(out_pass_valid), 64'd0);
            end else begin
                e = issue_q.pop_front();
                check("issue_cycle", 64'(cyc), 64'(e.cyc));
                check("issue_idx", 64'(out_pass_idx), 64'(e.idx));
                check("issue_mask", 64'(out_lane_mask), 64'(e.mask));
                check("issue_opcode", 64'(out_alu_opcode), 64'(e.op));
                check("issue_busy", 64'(out_busy), 64'd1);
            end
        end else if (issue_q.size() > 0 && issue_q[0].cyc <= cyc) begin
            e = issue_q.pop_front();
            check("issue_missing", 64'(out_pass_valid), 64'd1);
        end

        if (out_pass_capture === 1'b1) begin
            if (cap_q.size() == 0) begin
                check("capture_unexpected", 64'(out_pass_capture), 64'd0);
            end else begin
                e = cap_q.pop_front();
                check("capture_cycle", 64'(cyc), 64'(e.cyc));
                check("capture_idx", 64'(out_pass_idx), 64'(e.idx));
                check("capture_mask", 64'(out_lane_mask), 64'(e.mask));
                check("capture_opcode", 64'(out_alu_opcode), 64'(e.op));
            end
        end else if (cap_q.size() > 0 && cap_q[0].cyc <= cyc) begin
            e = cap_q.pop_front();
            check("capture_missing", 64'(out_pass_capture), 64'd1);
        end

        if (out_valu_done === 1'b1) begin
            if (done_q.size() == 0) begin
                check("done_unexpected", 64'(out_valu_done), 64'd0);
            end else begin
                d = done_q.pop_front();
                check("done_cycle", 64'(cyc), 64'(d.cyc));
                check("done_vcc", out_vcc_value, d.vcc);
                check("done_opcode", 64'(out_alu_opcode), 64'(d.op));
                check("done_busy", 64'(out_busy), 64'd1);
            end
        end else if (done_q.size() > 0 && done_q[0].cyc <= cyc) begin
            d = done_q.pop_front();
            check("done_missing", 64'(out_valu_done), 64'd1);
        end
    end

    // Advance one cycle; inputs change just after the falling edge. Inputs not
    // being qualified by start/capture get random garbage.
    task automatic tick();
        @(negedge clk);
        #1;
        rst            = 1'b0;
        in_alu_start   = 1'b0;
        in_alu_control = $urandom;
        in_exec_value  = {$urandom, $urandom};
        in_pass_cmp    = cmp_sched.exists(cyc) ? cmp_sched[cyc] : 16'($urandom);
    endtask

    // Present a start in the current cycle; the model decides from the
    // operation timing rules whether it is accepted and what must follow.
    task automatic start_op(input logic [31:0] op, input logic [63:0] exec,
                            input logic [63:0] cmps);
        int          c;
        int          per;
        int          iss;
        int          cap;
        logic [63:0] vcc;
        logic [15:0] m;
        logic [15:0] cv;
        c              = cyc;
        in_alu_start   = 1'b1;
        in_alu_control = op;
        in_exec_value  = exec;
        if (c > busy_end) begin
            per = (op[31:24] == 8'h08) ? LL : 1;
            if (exec == 64'd0) begin
                done_q.push_back('{c + 1, 64'd0, op});
                busy_end = c + 1;
            end else begin
                vcc = 64'd0;
                for (int p = 0; p < 4; p++) begin
                    m   = exec[16*p +: 16];
                    cv  = cmps[16*p +: 16];
                    iss = c + 1 + p * per;
                    cap = iss + per - 1;
                    issue_q.push_back('{iss, 2'(p), m, op});
                    cap_q.push_back('{cap, 2'(p), m, op});
                    cmp_sched[cap] = cv;
                    vcc[16*p +: 16] = cv & m;
                end
                done_q.push_back('{c + 1 + 4 * per, vcc, op});
                busy_end = c + 1 + 4 * per;
            end
        end
    endtask

    // Assert reset for the current cycle; next cycle everything must be zero.
    task automatic do_reset();
        rst = 1'b1;
        in_alu_start = 1'b0;
        issue_q.delete();
        cap_q.delete();
        done_q.delete();
        cmp_sched.delete();
        busy_end = cyc;
        tick();
        check("rst_busy", 64'(out_busy), 64'd0);
        check("rst_opcode", 64'(out_alu_opcode), 64'd0);
        check("rst_valid", 64'(out_pass_valid), 64'd0);
        check("rst_idx", 64'(out_pass_idx), 64'd0);
        check("rst_mask", 64'(out_lane_mask), 64'd0);
        check("rst_capture", 64'(out_pass_capture), 64'd0);
        check("rst_done", 64'(out_valu_done), 64'd0);
        check("rst_vcc", out_vcc_value, 64'd0);
    endtask

    task automatic wait_idle();
        while (cyc <= busy_end) tick();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    logic [63:0] rexec;
    logic [31:0] rop;
    int          t0;
    int          r;

    initial begin
        rst            = 1'b1;
        in_alu_start   = 1'b0;
        in_alu_control = '0;
        in_exec_value  = '0;
        in_pass_cmp    = '0;
        tick();
        do_reset();

        // Short op, re-pulse while busy, then back-to-back start after done.
        tick();
        t0 = cyc;
        start_op(32'h0100_0003, '1, {16'h0001, 16'hFFFF, 16'h0F0F, 16'hA5A5});
        ticks(3);
        start_op(32'h0800_0000, '1, {$urandom, $urandom});
        ticks(3);
        check("b2b_start_cycle", 64'(cyc), 64'(t0 + 6));
        start_op(32'h0200_0001, 64'h1234_5678_9ABC_DEF0, {$urandom, $urandom});
        wait_idle();

        // Long op, all lanes enabled.
        start_op(32'h0800_0010, '1, {$urandom, $urandom});
        wait_idle();

        // Partial EXEC.
        start_op(32'h0100_0000, 64'h0000_0000_FFFF_00FF, '1);
        wait_idle();

        // All-zero EXEC shortcut.
        start_op(32'h0800_0001, 64'd0, '1);
        wait_idle();

        // Opcode zero still runs as a short op.
        start_op(32'h0000_0000, 64'hFFFF_0000_FFFF_0000, {$urandom, $urandom});
        wait_idle();

        // Reset in the middle of a long op, then restart.
        t0 = cyc;
        start_op(32'h0800_0042, '1, {$urandom, $urandom});
        ticks(7);
        do_reset();
        tick();
        check("post_rst_start_cycle", 64'(cyc), 64'(t0 + 9));
        start_op(32'h0300_0007, {$urandom, $urandom}, {$urandom, $urandom});
        wait_idle();

        // Randomized traffic: starts at random moments (many ignored while
        // busy), mixed op lengths, sparse/zero EXEC, occasional reset.
        for (int i = 0; i < 400; i++) begin
            tick();
            r = $urandom_range(0, 39);
            if (r == 0) begin
                do_reset();
            end else if (r < 16) begin
                rop = $urandom;
                if ($urandom_range(0, 1) == 1) rop[31:24] = 8'h08;
                case ($urandom_range(0, 7))
                    0:       rexec = 64'd0;
                    1:       rexec = '1;
                    2:       rexec = {16'd0, 16'($urandom), 16'd0, 16'($urandom)};
                    default: rexec = {$urandom, $urandom};
                endcase
                start_op(rop, rexec, {$urandom, $urandom});
            end
        end

        ticks(25);
        check("drain_issue", 64'(issue_q.size()), 64'd0);
        check("drain_capture", 64'(cap_q.size()), 64'd0);
        check("drain_done", 64'(done_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
